vec_seq_ctrl: RTL and testbench

Execute-side sequencer for the vector ASIP. It takes the opcode and immediate produced by the ID-stage instruction decoder and owns the scalar index registers i, j and n. It updates them for INCRI/INCRJ/SETN and, for SUMFV/MULFV, issues n element operations one at a time to the shared floating-point unit through a start/done handshake. It stalls the front end while a vector operation is in flight.

---
 rtl/vec_seq_ctrl_if.sv | 43 ++++
 rtl/vec_seq_ctrl.sv | 117 +++++++++++
 tb/tb_vec_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_seq_ctrl_if.sv
// ============================================================================
// vec_seq_ctrl_if : decoder/FPU/front-end signal bundle for vec_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface vec_seq_ctrl_if #(
  parameter int ARQ   = 32,
  parameter int IDX_W = 8
);
  localparam int OPC_W = (ARQ - 3) - (ARQ - 6) + 1;
  localparam int IMM_W = 24;

  logic             op_valid;
  logic [OPC_W-1:0] opcode;
  logic [IMM_W-1:0] imm;
  logic             stall;
  logic [IDX_W-1:0] i_reg;
  logic [IDX_W-1:0] j_reg;
  logic [IDX_W-1:0] n_reg;
  logic [IDX_W-1:0] elem_addr;
  logic             fpu_start;
  logic             fpu_op;
  logic             fpu_last;
  logic             fpu_done;
  logic             vec_done;

  // Environment side: decoder, front end and FPU.
  modport master (
    output op_valid, opcode, imm, fpu_done,
    input  stall, i_reg, j_reg, n_reg, elem_addr, fpu_start, fpu_op,
           fpu_last, vec_done
  );

  // Sequencer side.
  modport slave (
    input  op_valid, opcode, imm, fpu_done,
    output stall, i_reg, j_reg, n_reg, elem_addr, fpu_start, fpu_op,
           fpu_last, vec_done
  );
endinterface

`default_nettype wire

// File: rtl/vec_seq_ctrl.sv
// ============================================================================
// vec_seq_ctrl : execute-side sequencer owning i/j/n and issuing vector
//                element operations to the shared FPU.  Rev 1.0
// ============================================================================
`default_nettype none

module vec_seq_ctrl #(
  parameter int ARQ   = 32,
  parameter int IDX_W = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  vec_seq_ctrl_if.slave bus
);
  localparam int OPC_W = (ARQ - 3) - (ARQ - 6) + 1;
  localparam int IMM_W = 24;

  localparam logic [OPC_W-1:0] OPC_INCRI = OPC_W'(0);
  localparam logic [OPC_W-1:0] OPC_INCRJ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OPC_SETN  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_SUMFV = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_MULFV = OPC_W'(4);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic             op_q, op_d;
  logic             last_elem;

  // n cannot change while a vector op is in flight, so n_q is the count
  // sampled at acceptance.
  assign last_elem = (cnt_q == (n_q - ONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    n_d     = n_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          case (bus.opcode)
            OPC_INCRI: i_d = i_q + ONE;
            OPC_INCRJ: j_d = j_q + ONE;
            OPC_SETN:  n_d = bus.imm[IDX_W-1:0];
            OPC_SUMFV, OPC_MULFV: begin
              op_d    = (bus.opcode == OPC_MULFV);
              cnt_d   = '0;
              state_d = (n_q == '0) ? S_DONE : S_ISSUE;
            end
            default: ;
          endcase
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.fpu_done) begin
          if (last_elem) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + ONE;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      n_q     <= n_d;
      op_q    <= op_d;
    end
  end

  // All outputs decode registered state only.
  assign bus.stall     = (state_q != S_IDLE);
  assign bus.fpu_start = (state_q == S_ISSUE);
  assign bus.fpu_last  = (state_q == S_ISSUE) && last_elem;
  assign bus.vec_done  = (state_q == S_DONE);
  assign bus.elem_addr = cnt_q;
  assign bus.fpu_op    = op_q;
  assign bus.i_reg     = i_q;
  assign bus.j_reg     = j_q;
  assign bus.n_reg     = n_q;

  logic unused_imm;
  assign unused_imm = ^bus.imm[IMM_W-1:IDX_W];

endmodule

`default_nettype wire

// File: tb/tb_vec_seq_ctrl.sv
// ============================================================================
// tb_vec_seq_ctrl : directed stimulus with a scoreboard of expected FPU
//                   issues and vec_done pulses.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_vec_seq_ctrl;
  localparam logic [3:0] INCRI = 4'd0;
  localparam logic [3:0] INCRJ = 4'd1;
  localparam logic [3:0] SETN  = 4'd2;
  localparam logic [3:0] SUMFV = 4'd3;
  localparam logic [3:0] MULFV = 4'd4;
  localparam logic [3:0] NOP   = 4'd5;

  typedef struct {
    bit         is_done;
    logic [7:0] addr;
    logic       op;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  vec_seq_ctrl_if #(.ARQ(32), .IDX_W(8)) bus ();

  vec_seq_ctrl #(.ARQ(32), .IDX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.fpu_done = model_done | spur_done;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FPU model: completion two cycles after each start.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.fpu_start && !rst) begin
        @(posedge clk);
        @(posedge clk);
        #1 model_done = 1'b1;
        @(posedge clk);
        #1 model_done = 1'b0;
      end
    end
  end

  // Monitor: every start or vec_done pops the next expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.fpu_start || bus.vec_done) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {30'd0, bus.fpu_start, bus.vec_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.is_done)
            check("vec_done_event", {31'd0, bus.vec_done}, 32'd1);
          else
            check("fpu_issue", {20'd0, bus.fpu_start, bus.elem_addr, bus.fpu_op, bus.fpu_last},
                  {20'd0, 1'b1, e.addr, e.op, e.last});
        end
      end
    end
  end

  task automatic issue(input logic [3:0] opc, input logic [23:0] imm);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.opcode   = opc;
    bus.imm      = imm;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  // Issues a vector op, pushes its expected events and measures stall.
  task automatic run_vec(input logic [3:0] opc, input int n, input bit flood, input bit spur,
                         output int stall_cyc, output int done_at);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.is_done = 1'b0;
      e.addr    = 8'(k);
      e.op      = (opc == MULFV);
      e.last    = (k == n - 1);
      sb.push_back(e);
    end
    e.is_done = 1'b1; e.addr = 8'd0; e.op = 1'b0; e.last = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.opcode   = opc;
    @(posedge clk); #1;
    bus.op_valid = flood;
    bus.opcode   = INCRI;
    spur_done    = spur;
    stall_cyc = 0;
    done_at   = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (!bus.stall) break;
      stall_cyc++;
      if (bus.vec_done) done_at = c;
      if (c == 3000) check("vec_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      spur_done    = 1'b0;
      bus.op_valid = flood && bus.stall;
    end
    bus.op_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] seq[6];
    int exp_i, exp_j, sc, da, i_before;
    bit found;
    exp_t e;
    bus.op_valid = 1'b0;
    bus.opcode   = NOP;
    bus.imm      = 24'd0;
    seq = '{INCRI, INCRI, INCRI, INCRJ, INCRJ, NOP};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {25'd0, bus.stall, bus.fpu_start, bus.fpu_op, bus.fpu_last, bus.vec_done, 2'd0}, 32'd0);
    check("rst_elem_addr", 32'(bus.elem_addr), 32'd0);
    check("rst_regs", {8'd0, bus.i_reg, bus.j_reg, bus.n_reg}, 32'd0);

    // Back-to-back scalar ops, each visible one cycle later.
    exp_i = 0; exp_j = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.op_valid = (k < 5);
      bus.opcode   = seq[k];
      @(negedge clk);
      check("scalar_i", 32'(bus.i_reg), 32'(exp_i));
      check("scalar_j", 32'(bus.j_reg), 32'(exp_j));
      if (k < 5 && seq[k] == INCRI) exp_i++;
      if (k < 5 && seq[k] == INCRJ) exp_j++;
    end
    bus.op_valid = 1'b0;
    bus.opcode   = NOP;

    // j wraps after 256 increments from reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.opcode   = INCRJ;
      if (k == 200) begin
        @(negedge clk);
        check("j_count_200", 32'(bus.j_reg), 32'd200);
      end
    end
    @(posedge clk); #1 bus.op_valid = 1'b0;
    @(negedge clk);
    check("j_wrap", 32'(bus.j_reg), 32'd0);
    issue(SETN, 24'hFFFF08);
    @(negedge clk);
    check("setn_low_bits", 32'(bus.n_reg), 32'h08);

    // SUMFV, n=3.
    issue(SETN, 24'd3);
    run_vec(SUMFV, 3, 1'b0, 1'b0, sc, da);
    check("sumfv3_stall_cycles", 32'(sc), 32'd10);
    check("sumfv3_done_cycle", 32'(da), 32'd10);

    // MULFV with n=0: straight to DONE.
    issue(SETN, 24'd0);
    run_vec(MULFV, 0, 1'b0, 1'b0, sc, da);
    check("mulfv0_stall_cycles", 32'(sc), 32'd1);
    check("mulfv0_done_cycle", 32'(da), 32'd1);

    // MULFV n=4 under INCRI flood and a spurious fpu_done in ISSUE.
    issue(INCRI, 24'd0);
    @(negedge clk);
    i_before = int'(bus.i_reg);
    issue(SETN, 24'd4);
    run_vec(MULFV, 4, 1'b1, 1'b1, sc, da);
    @(negedge clk);
    check("flood_i_unchanged", 32'(bus.i_reg), 32'(i_before));
    check("mulfv4_stall_cycles", 32'(sc), 32'd13);
    check("flood_n_kept", 32'(bus.n_reg), 32'd4);

    // Reset while waiting on element 1.
    issue(INCRJ, 24'd0);
    issue(SETN, 24'd3);
    for (int k = 0; k < 2; k++) begin
      e.is_done = 1'b0; e.addr = 8'(k); e.op = 1'b0; e.last = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.opcode   = SUMFV;
    @(posedge clk); #1 bus.op_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.fpu_start && bus.elem_addr == 8'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_elem1", 32'(found), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", {27'd0, bus.stall, bus.fpu_start, bus.fpu_op, bus.fpu_last, bus.vec_done}, 32'd0);
    check("midrst_regs", {bus.elem_addr, bus.i_reg, bus.j_reg, bus.n_reg}, 32'd0);
    repeat (4) @(negedge clk);
    issue(SETN, 24'd2);
    run_vec(SUMFV, 2, 1'b0, 1'b0, sc, da);
    check("post_rst_stall_cycles", 32'(sc), 32'd7);
    check("post_rst_done_cycle", 32'(da), 32'd7);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
